// File: rtl/rvh_l1d_line_refill_buf_pkg.sv
// rvh_l1d_line_refill_buf_pkg: shared sizes, R-beat layout and refill FSM states
package rvh_l1d_line_refill_buf_pkg;
    localparam int N_MSHR                   = 4;
    localparam int N_MSHR_W                 = 2;
    localparam int MEM_DATA_WIDTH           = 64;
    localparam int BURST_SIZE               = 8;
    localparam int BEAT_CNT_W               = 3;
    localparam int LINE_W                   = MEM_DATA_WIDTH * BURST_SIZE;
    localparam int MEMNOC_TID_MASTERID_SIZE = 4;
    localparam int MEMNOC_TID_TID_SIZE      = 4;
    localparam int RID_W                    = MEMNOC_TID_MASTERID_SIZE + MEMNOC_TID_TID_SIZE;

    typedef struct packed {
        logic [RID_W-1:0]          rid;
        logic [MEM_DATA_WIDTH-1:0] rdata;
        logic [1:0]                rresp;
        logic                      rlast;
    } r_beat_t;

    typedef enum logic [1:0] {COLLECT, REFILL, DEALLOC} refill_state_e;
endpackage

// File: rtl/rvh_l1d_line_refill_buf_beat_assembler.sv
// rvh_l1d_line_refill_buf_beat_assembler: packs R beats into a line, tracks MSHR id and error
module rvh_l1d_line_refill_buf_beat_assembler
    import rvh_l1d_line_refill_buf_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      beat_en_i,
    input  logic                      err_clr_i,
    input  logic [MEM_DATA_WIDTH-1:0] rdata_i,
    input  logic [1:0]                rresp_i,
    input  logic                      rlast_i,
    input  logic [N_MSHR_W-1:0]       mshr_id_i,
    output logic                      line_done_o,
    output logic [LINE_W-1:0]         line_o,
    output logic                      err_o,
    output logic [N_MSHR_W-1:0]       mshr_id_o
);
    logic [BEAT_CNT_W-1:0] cnt_q, cnt_d;
    logic [LINE_W-1:0]     line_q, line_d;
    logic                  err_q, err_d;
    logic [N_MSHR_W-1:0]   id_q, id_d;
    logic                  last_beat;

    assign last_beat   = cnt_q == BEAT_CNT_W'(BURST_SIZE - 1);
    assign line_done_o = beat_en_i & last_beat;
    assign line_o      = line_q;
    assign err_o       = err_q;
    assign mshr_id_o   = id_q;

    // rlast on the wrong beat only flags an error; the count alone closes the line
    always_comb begin
        cnt_d  = beat_en_i ? cnt_q + 1'b1 : cnt_q;
        line_d = line_q;
        if (beat_en_i)
            line_d[cnt_q*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] = rdata_i;
        err_d  = err_clr_i ? 1'b0 : err_q | (beat_en_i & ((rresp_i != 2'b00) | (rlast_i != last_beat)));
        id_d   = (beat_en_i && cnt_q == '0) ? mshr_id_i : id_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            line_q <= '0;
            err_q  <= 1'b0;
            id_q   <= '0;
        end else begin
            cnt_q  <= cnt_d;
            line_q <= line_d;
            err_q  <= err_d;
            id_q   <= id_d;
        end
    end
endmodule

// File: rtl/rvh_l1d_line_refill_buf.sv
// rvh_l1d_line_refill_buf: collects an 8-beat L2 R burst into a line, hands it to refill,
// then frees the owning MSHR entry
module rvh_l1d_line_refill_buf
    import rvh_l1d_line_refill_buf_pkg::*;
#(
    parameter logic [3:0] BANK_ID = 4'd0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      l2_resp_if_rvalid,
    output logic                      l2_resp_if_rready,
    input  logic [RID_W-1:0]          l2_resp_if_rid,
    input  logic [MEM_DATA_WIDTH-1:0] l2_resp_if_rdata,
    input  logic [1:0]                l2_resp_if_rresp,
    input  logic                      l2_resp_if_rlast,
    input  logic [N_MSHR-1:0]         mshr_bank_no_resp_i,
    output logic                      refill_valid_o,
    input  logic                      refill_ready_i,
    output logic [N_MSHR_W-1:0]       refill_mshr_id_o,
    output logic [LINE_W-1:0]         refill_line_o,
    output logic                      refill_err_o,
    output logic                      refill_no_resp_o,
    output logic                      mlfb_mshr_dealloc_valid_o,
    output logic [N_MSHR_W-1:0]       mlfb_mshr_dealloc_idx_o,
    input  logic                      mlfb_mshr_dealloc_ready_i
);
    refill_state_e state_q;
    r_beat_t       beat;
    logic          beat_en;
    logic          line_done;
    logic          no_resp_q;

    assign beat = '{rid: l2_resp_if_rid, rdata: l2_resp_if_rdata,
                    rresp: l2_resp_if_rresp, rlast: l2_resp_if_rlast};

    assign l2_resp_if_rready         = state_q == COLLECT;
    assign beat_en                   = l2_resp_if_rvalid & l2_resp_if_rready;
    assign refill_valid_o            = state_q == REFILL;
    assign mlfb_mshr_dealloc_valid_o = state_q == DEALLOC;
    assign mlfb_mshr_dealloc_idx_o   = refill_mshr_id_o;
    assign refill_no_resp_o          = no_resp_q;

    rvh_l1d_line_refill_buf_beat_assembler u_asm (
        .clk         (clk),
        .rst         (rst),
        .beat_en_i   (beat_en),
        .err_clr_i   (mlfb_mshr_dealloc_valid_o & mlfb_mshr_dealloc_ready_i),
        .rdata_i     (beat.rdata),
        .rresp_i     (beat.rresp),
        .rlast_i     (beat.rlast),
        .mshr_id_i   (beat.rid[N_MSHR_W-1:0]),
        .line_done_o (line_done),
        .line_o      (refill_line_o),
        .err_o       (refill_err_o),
        .mshr_id_o   (refill_mshr_id_o)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= COLLECT;
            no_resp_q <= 1'b0;
        end else begin
            case (state_q)
                COLLECT: if (line_done) begin
                    state_q   <= REFILL;
                    no_resp_q <= mshr_bank_no_resp_i[refill_mshr_id_o];
                end
                REFILL:  if (refill_ready_i) state_q <= DEALLOC;
                DEALLOC: if (mlfb_mshr_dealloc_ready_i) state_q <= COLLECT;
                default: state_q <= COLLECT;
            endcase
        end
    end

    // Misrouted or malformed ids are still consumed; these only flag them in simulation
    a_master_id: assert property (@(posedge clk) disable iff (!rst)
        beat_en |-> beat.rid[7:4] == {1'b0, BANK_ID[2:0]});
    a_tid_hi: assert property (@(posedge clk) disable iff (!rst)
        beat_en |-> beat.rid[3:2] == 2'b00);
endmodule

// File: tb/tb_rvh_l1d_line_refill_buf.sv
// tb_rvh_l1d_line_refill_buf: table vectors, corner sequences and random lines checked
// against a line-level model of the refill buffer
module tb_rvh_l1d_line_refill_buf;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         rvalid = 1'b0;
    logic         rready;
    logic [7:0]   rid = '0;
    logic [63:0]  rdata = '0;
    logic [1:0]   rresp = '0;
    logic         rlast = 1'b0;
    logic [3:0]   nr_mask = '0;
    logic         refill_valid;
    logic         refill_ready = 1'b0;
    logic [1:0]   refill_id;
    logic [511:0] refill_line;
    logic         refill_err;
    logic         refill_nr;
    logic         dealloc_valid;
    logic [1:0]   dealloc_idx;
    logic         dealloc_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    logic [63:0] bd [8];
    logic [1:0]  br [8];
    logic        bl [8];

    typedef struct {
        logic [7:0] rid;
        logic [7:0] bad;
        logic [1:0] bresp;
        logic [7:0] last;
        logic [3:0] nr;
        int         rs;
        int         ds;
        bit         hold;
        bit         err;
        bit         nr_exp;
    } vec_t;
    vec_t tbl [9];

    always #5 clk = ~clk;

    rvh_l1d_line_refill_buf dut (
        .clk                       (clk),
        .rst                       (rst),
        .l2_resp_if_rvalid         (rvalid),
        .l2_resp_if_rready         (rready),
        .l2_resp_if_rid            (rid),
        .l2_resp_if_rdata          (rdata),
        .l2_resp_if_rresp          (rresp),
        .l2_resp_if_rlast          (rlast),
        .mshr_bank_no_resp_i       (nr_mask),
        .refill_valid_o            (refill_valid),
        .refill_ready_i            (refill_ready),
        .refill_mshr_id_o          (refill_id),
        .refill_line_o             (refill_line),
        .refill_err_o              (refill_err),
        .refill_no_resp_o          (refill_nr),
        .mlfb_mshr_dealloc_valid_o (dealloc_valid),
        .mlfb_mshr_dealloc_idx_o   (dealloc_idx),
        .mlfb_mshr_dealloc_ready_i (dealloc_ready)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_line(input logic [7:0] id, input logic [3:0] nr, input int gap_max,
                            input int rstall, input int dstall, input bit hold,
                            input bit exp_err, input bit exp_nr);
        logic [511:0] el;
        for (int k = 0; k < 8; k++) el[k*64 +: 64] = bd[k];
        nr_mask = nr;
        for (int k = 0; k < 8; k++) begin
            rvalid = 1'b0;
            repeat (gap_max > 0 ? $urandom_range(gap_max, 0) : 0) begin
                tick;
                chk("no_refill_in_gap", refill_valid, 1'b0);
            end
            rvalid = 1'b1;
            rid    = id;
            rdata  = bd[k];
            rresp  = br[k];
            rlast  = bl[k];
            chk("rready_collect", rready, 1'b1);
            tick;
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        chk("refill_valid_latency", refill_valid, 1'b1);
        chk("refill_line", refill_line, el);
        chk("refill_id", refill_id, id[1:0]);
        chk("refill_err", refill_err, exp_err);
        chk("refill_no_resp", refill_nr, exp_nr);
        chk("rready_refill", rready, 1'b0);
        if (hold) begin
            rvalid = 1'b1;
            rdata  = 64'hDEAD_BEEF_0BAD_F00D;
            rresp  = 2'b00;
        end
        for (int c = 0; c < rstall; c++) begin
            tick;
            chk("refill_hold_valid", refill_valid, 1'b1);
            chk("refill_hold_line", refill_line, el);
            chk("refill_hold_id", refill_id, id[1:0]);
            chk("rready_stall", rready, 1'b0);
        end
        refill_ready  = 1'b1;
        dealloc_ready = dstall == 0;
        tick;
        refill_ready = 1'b0;
        for (int c = 0; c <= dstall; c++) begin
            chk("dealloc_valid", dealloc_valid, 1'b1);
            chk("dealloc_idx", dealloc_idx, id[1:0]);
            chk("refill_drop", refill_valid, 1'b0);
            chk("rready_dealloc", rready, 1'b0);
            if (c == dstall) dealloc_ready = 1'b1;
            tick;
        end
        rvalid = 1'b0;
        chk("dealloc_done", dealloc_valid, 1'b0);
        chk("rready_back", rready, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{8'h02, 8'h00, 2'b00, 8'h80, 4'b0000, 0, 0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{8'h01, 8'h08, 2'b10, 8'h80, 4'b0000, 5, 0, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{8'h03, 8'h00, 2'b00, 8'h80, 4'b0000, 0, 0, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{8'h01, 8'h00, 2'b00, 8'h80, 4'b0010, 1, 0, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{8'h00, 8'h00, 2'b00, 8'h80, 4'b0010, 0, 0, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{8'h02, 8'h00, 2'b00, 8'h80, 4'b0000, 0, 3, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{8'h03, 8'h00, 2'b00, 8'h88, 4'b0000, 0, 0, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{8'h00, 8'h00, 2'b00, 8'h00, 4'b0000, 0, 0, 1'b0, 1'b1, 1'b0};
        tbl[8] = '{8'h01, 8'h01, 2'b11, 8'h80, 4'b1111, 2, 1, 1'b1, 1'b1, 1'b1};

        repeat (2) tick;
        chk("reset_rready", rready, 1'b1);
        chk("reset_refill_valid", refill_valid, 1'b0);
        chk("reset_dealloc_valid", dealloc_valid, 1'b0);
        chk("reset_line", refill_line, '0);
        chk("reset_id", refill_id, 2'd0);
        chk("reset_err", refill_err, 1'b0);
        chk("reset_no_resp", refill_nr, 1'b0);
        chk("reset_idx", dealloc_idx, 2'd0);
        rst = 1'b1;
        tick;

        for (int i = 0; i < 9; i++) begin
            for (int k = 0; k < 8; k++) begin
                bd[k] = i == 0 ? 64'(k) : {$urandom(), $urandom()};
                br[k] = tbl[i].bad[k] ? tbl[i].bresp : 2'b00;
                bl[k] = tbl[i].last[k];
            end
            run_line(tbl[i].rid, tbl[i].nr, 0, tbl[i].rs, tbl[i].ds, tbl[i].hold,
                     tbl[i].err, tbl[i].nr_exp);
        end

        // Reset arriving after half a line must discard it without any refill or dealloc
        for (int k = 0; k < 4; k++) begin
            rvalid = 1'b1;
            rid    = 8'h03;
            rdata  = 64'hAAAA_0000_0000_0000 | 64'(k);
            rresp  = 2'b01;
            rlast  = 1'b0;
            tick;
        end
        rvalid = 1'b0;
        rst    = 1'b0;
        #1;
        chk("midreset_rready", rready, 1'b1);
        chk("midreset_refill_valid", refill_valid, 1'b0);
        chk("midreset_dealloc_valid", dealloc_valid, 1'b0);
        chk("midreset_line", refill_line, '0);
        chk("midreset_err", refill_err, 1'b0);
        tick;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick;
            chk("postreset_no_refill", refill_valid, 1'b0);
            chk("postreset_no_dealloc", dealloc_valid, 1'b0);
        end
        for (int k = 0; k < 8; k++) begin
            bd[k] = 64'h5555_0000_0000_0000 | 64'(k);
            br[k] = 2'b00;
            bl[k] = k == 7;
        end
        run_line(8'h02, 4'b0000, 0, 0, 0, 1'b0, 1'b0, 1'b0);

        // Random lines against a line-level model: line = beats in order,
        // err = any non-OKAY beat or rlast not exactly on the 8th beat
        for (int i = 0; i < 40; i++) begin
            logic [7:0] id;
            logic [3:0] nr;
            bit         ee;
            id = {6'd0, 2'($urandom_range(3, 0))};
            nr = 4'($urandom());
            ee = 1'b0;
            for (int k = 0; k < 8; k++) begin
                bd[k] = {$urandom(), $urandom()};
                br[k] = $urandom_range(15, 0) == 0 ? 2'($urandom_range(3, 1)) : 2'b00;
                bl[k] = $urandom_range(7, 0) == 0 ? 1'($urandom()) : (k == 7);
                if (br[k] != 2'b00 || bl[k] != (k == 7)) ee = 1'b1;
            end
            run_line(id, nr, 2, $urandom_range(3, 0), $urandom_range(3, 0),
                     1'($urandom()), ee, nr[id[1:0]]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
